// File: rtl/gate_pkg.sv
// gate_pkg: shared state encoding and gain constants
// for the noise gate post-processing stage.
package gate_pkg;

  localparam int GAIN_W = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  typedef enum logic [2:0] {
    CLOSED_S,
    ATTACK_S,
    OPEN_S,
    HOLD_S,
    RELEASE_S
  } gate_state_e;

endpackage

// File: rtl/attenuator.sv
// attenuator: signed sample times unsigned gain,
// 256 = unity, arithmetic shift back by 8.
module attenuator
  import gate_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic signed [DWIDTH-1:0] data_signed_i,
  input  logic        [GAIN_W-1:0] mult_i,
  output logic signed [DWIDTH-1:0] data_o
);

  localparam int SHIFT = GAIN_W - 1;

  logic signed [DWIDTH+GAIN_W:0] prod;
  logic                          unused_bits;

  assign prod = data_signed_i * $signed({1'b0, mult_i});
  assign data_o = prod[DWIDTH+SHIFT-1:SHIFT];
  assign unused_bits = ^{prod[DWIDTH+GAIN_W:DWIDTH+SHIFT],
                         prod[SHIFT-1:0]};

endmodule

// File: rtl/noise_gate.sv
// noise_gate: peak-envelope driven hysteretic gate with
// ramped gain, muting hiss between swelled notes.
module noise_gate
  import gate_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int DECAY_SHIFT  = 4,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 1,
  parameter int HOLD_W       = 16
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     sample_tick_i,
  input  logic                     enable_i,
  input  logic [DWIDTH-2:0]        open_level_i,
  input  logic [DWIDTH-2:0]        close_level_i,
  input  logic [HOLD_W-1:0]        hold_samples_i,
  input  logic signed [DWIDTH-1:0] data_i,
  output logic signed [DWIDTH-1:0] data_o,
  output logic                     gate_open_o
);

  localparam logic [GAIN_W:0] ATK =
    (GAIN_W+1)'(ATTACK_STEP);
  localparam logic [GAIN_W-1:0] REL =
    GAIN_W'(RELEASE_STEP);

  gate_state_e state_q, state_n;
  logic [GAIN_W-1:0] gain_q, gain_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic [DWIDTH-2:0] peak_q, peak_n;
  logic [DWIDTH-2:0] mag, peak_dec;
  logic [GAIN_W:0]   gain_up;
  logic [GAIN_W-1:0] gain_atk, gain_rel;
  logic signed [DWIDTH-1:0] scaled;
  logic              above_open;

  assign mag = data_i[DWIDTH-1] ? ~data_i[DWIDTH-2:0]
                                :  data_i[DWIDTH-2:0];
  assign peak_dec = peak_q >> DECAY_SHIFT;
  assign above_open = peak_q >= open_level_i;

  assign gain_up = {1'b0, gain_q} + ATK;
  assign gain_atk = (gain_up > {1'b0, GAIN_UNITY})
                    ? GAIN_UNITY : gain_up[GAIN_W-1:0];
  assign gain_rel = (gain_q > REL) ? gain_q - REL : '0;

  assign gate_open_o = (state_q == ATTACK_S) ||
                       (state_q == OPEN_S) ||
                       (state_q == HOLD_S);

  attenuator #(
    .DWIDTH(DWIDTH)
  ) u_att (
    .data_signed_i(data_i),
    .mult_i       (gain_q),
    .data_o       (scaled)
  );

  // peak envelope: instant attack, proportional decay,
  // unit steps once the proportional term vanishes
  always_comb begin
    peak_n = peak_q;
    if (mag > peak_q)
      peak_n = mag;
    else if (peak_dec != '0)
      peak_n = peak_q - peak_dec;
    else if (peak_q != '0)
      peak_n = peak_q - (DWIDTH-1)'(1);
  end

  // gate state machine and gain ramp, next-state logic
  always_comb begin
    state_n = state_q;
    gain_n  = gain_q;
    hold_n  = hold_q;
    unique case (state_q)
      CLOSED_S: begin
        if (above_open) state_n = ATTACK_S;
      end
      ATTACK_S: begin
        gain_n = gain_atk;
        if (gain_atk == GAIN_UNITY) state_n = OPEN_S;
      end
      OPEN_S: begin
        gain_n = GAIN_UNITY;
        if (peak_q < close_level_i) begin
          state_n = HOLD_S;
          hold_n  = hold_samples_i;
        end
      end
      HOLD_S: begin
        gain_n = GAIN_UNITY;
        if (above_open)
          state_n = OPEN_S;
        else if (hold_q == '0)
          state_n = RELEASE_S;
        else
          hold_n = hold_q - HOLD_W'(1);
      end
      RELEASE_S: begin
        if (above_open) begin
          state_n = ATTACK_S;
        end else begin
          gain_n = gain_rel;
          if (gain_rel == '0) state_n = CLOSED_S;
        end
      end
      default: state_n = CLOSED_S;
    endcase
  end

  // registers: bypass pins the gate open at unity,
  // everything else advances only on the sample tick
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= CLOSED_S;
      gain_q  <= '0;
      hold_q  <= '0;
      peak_q  <= '0;
      data_o  <= '0;
    end else begin
      if (sample_tick_i) begin
        peak_q <= peak_n;
        data_o <= enable_i ? scaled : data_i;
      end
      if (!enable_i) begin
        state_q <= OPEN_S;
        gain_q  <= GAIN_UNITY;
        hold_q  <= '0;
      end else if (sample_tick_i) begin
        state_q <= state_n;
        gain_q  <= gain_n;
        hold_q  <= hold_n;
      end
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// tb_noise_gate: directed scenarios for the noise gate,
// one task per behaviour, ticks every 4 clocks.
module tb_noise_gate;

  logic               clk_i = 1'b0;
  logic               srst_i;
  logic               sample_tick_i;
  logic               enable_i;
  logic [14:0]        open_level_i;
  logic [14:0]        close_level_i;
  logic [15:0]        hold_samples_i;
  logic signed [15:0] data_i;
  logic signed [15:0] data_o;
  logic               gate_open_o;

  int checks = 0;
  int errors = 0;

  noise_gate dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .sample_tick_i (sample_tick_i),
    .enable_i      (enable_i),
    .open_level_i  (open_level_i),
    .close_level_i (close_level_i),
    .hold_samples_i(hold_samples_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .gate_open_o   (gate_open_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input logic signed [15:0] d);
    @(negedge clk_i);
    data_i = d;
    sample_tick_i = 1'b1;
    @(negedge clk_i);
    sample_tick_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    srst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    srst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    srst_i = 1'b1;
    sample_tick_i = 1'b1;
    data_i = 16'sd5000;
    repeat (3) @(negedge clk_i);
    checks++;
    if (data_o !== 16'sd0 || gate_open_o !== 1'b0) begin
      $display("FAIL reset data_o=%0d gate=%b exp 0/0",
               data_o, gate_open_o);
      errors++;
    end
    srst_i = 1'b0;
    sample_tick_i = 1'b0;
    enable_i = 1'b1;
    open_level_i = 15'd2000;
    close_level_i = 15'd1000;
    hold_samples_i = 16'd5;
    for (int i = 0; i < 2; i++) begin
      tick(16'sd1000);
      checks++;
      if (data_o !== 16'sd0 || gate_open_o !== 1'b0) begin
        $display("FAIL reset_low t%0d data_o=%0d gate=%b exp 0/0",
                 i, data_o, gate_open_o);
        errors++;
      end
    end
  endtask

  task automatic test_open_ramp();
    logic signed [15:0] exp;
    do_reset();
    open_level_i = 15'd2000;
    close_level_i = 15'd1000;
    hold_samples_i = 16'd5;
    tick(16'sd8000);
    checks++;
    if (data_o !== 16'sd0 || gate_open_o !== 1'b0) begin
      $display("FAIL ramp t1 data_o=%0d gate=%b exp 0/0",
               data_o, gate_open_o);
      errors++;
    end
    tick(16'sd8000);
    checks++;
    if (data_o !== 16'sd0 || gate_open_o !== 1'b1) begin
      $display("FAIL ramp t2 data_o=%0d gate=%b exp 0/1",
               data_o, gate_open_o);
      errors++;
    end
    for (int n = 3; n <= 21; n++) begin
      tick(16'sd8000);
      exp = (n <= 18) ? 16'(500 * (n - 3)) : 16'sd8000;
      checks++;
      if (data_o !== exp || gate_open_o !== 1'b1) begin
        $display("FAIL ramp t%0d data_o=%0d gate=%b exp %0d/1",
                 n, data_o, gate_open_o, exp);
        errors++;
      end
    end
  endtask

  task automatic test_hold_release();
    logic signed [15:0] exp;
    open_level_i = 15'd20000;
    close_level_i = 15'd20000;
    hold_samples_i = 16'd5;
    for (int h = 1; h <= 7; h++) begin
      tick(16'sd4000);
      checks++;
      if (data_o !== 16'sd4000 ||
          gate_open_o !== (h <= 6)) begin
        $display("FAIL hold h%0d data_o=%0d gate=%b exp 4000/%b",
                 h, data_o, gate_open_o, (h <= 6));
        errors++;
      end
    end
    for (int k = 0; k <= 155; k++) begin
      tick(16'sd4000);
      exp = 16'((4000 * (256 - k)) / 256);
      checks++;
      if (data_o !== exp || gate_open_o !== 1'b0) begin
        $display("FAIL release k%0d data_o=%0d gate=%b exp %0d/0",
                 k, data_o, gate_open_o, exp);
        errors++;
      end
    end
  endtask

  task automatic test_retrigger();
    logic signed [15:0] exp;
    int pre;
    open_level_i = 15'd2000;
    close_level_i = 15'd1000;
    tick(-16'sd8000);
    checks++;
    if (data_o !== -16'sd3125 || gate_open_o !== 1'b1) begin
      $display("FAIL retrig r1 data_o=%0d gate=%b exp -3125/1",
               data_o, gate_open_o);
      errors++;
    end
    for (int n = 2; n <= 13; n++) begin
      tick(-16'sd8000);
      pre = (n <= 11) ? 100 + 16 * (n - 2) : 256;
      exp = 16'(-(8000 * pre) / 256);
      checks++;
      if (data_o !== exp || gate_open_o !== 1'b1) begin
        $display("FAIL retrig r%0d data_o=%0d gate=%b exp %0d/1",
                 n, data_o, gate_open_o, exp);
        errors++;
      end
    end
  endtask

  task automatic test_release_zero();
    logic signed [15:0] exp;
    open_level_i = 15'd20000;
    close_level_i = 15'd20000;
    hold_samples_i = 16'd0;
    tick(16'sd4000);
    tick(16'sd4000);
    checks++;
    if (data_o !== 16'sd4000 || gate_open_o !== 1'b0) begin
      $display("FAIL hold0 data_o=%0d gate=%b exp 4000/0",
               data_o, gate_open_o);
      errors++;
    end
    for (int k = 0; k <= 257; k++) begin
      tick(16'sd4000);
      exp = (k <= 255) ? 16'((4000 * (256 - k)) / 256)
                       : 16'sd0;
      checks++;
      if (data_o !== exp || gate_open_o !== 1'b0) begin
        $display("FAIL to_zero k%0d data_o=%0d gate=%b exp %0d/0",
                 k, data_o, gate_open_o, exp);
        errors++;
      end
    end
  endtask

  task automatic test_bypass();
    enable_i = 1'b0;
    tick(16'sd4000);
    checks++;
    if (data_o !== 16'sd4000 || gate_open_o !== 1'b1) begin
      $display("FAIL byp_closed data_o=%0d gate=%b exp 4000/1",
               data_o, gate_open_o);
      errors++;
    end
    enable_i = 1'b1;
    tick(16'sd4000);
    tick(16'sd4000);
    tick(16'sd4000);
    tick(16'sd4000);
    checks++;
    if (data_o !== 16'sd3984 || gate_open_o !== 1'b0) begin
      $display("FAIL byp_rel data_o=%0d gate=%b exp 3984/0",
               data_o, gate_open_o);
      errors++;
    end
    enable_i = 1'b0;
    tick(-16'sd12345);
    checks++;
    if (data_o !== -16'sd12345 || gate_open_o !== 1'b1) begin
      $display("FAIL byp_neg data_o=%0d gate=%b exp -12345/1",
               data_o, gate_open_o);
      errors++;
    end
    tick(16'sd12345);
    checks++;
    if (data_o !== 16'sd12345) begin
      $display("FAIL byp_pos data_o=%0d exp 12345", data_o);
      errors++;
    end
    enable_i = 1'b1;
    open_level_i = 15'd2000;
    close_level_i = 15'd1000;
    for (int e = 1; e <= 3; e++) begin
      tick(16'sd3000);
      checks++;
      if (data_o !== 16'sd3000 || gate_open_o !== 1'b1) begin
        $display("FAIL reenable e%0d data_o=%0d gate=%b exp 3000/1",
                 e, data_o, gate_open_o);
        errors++;
      end
    end
  endtask

  task automatic test_peak_decay();
    do_reset();
    open_level_i = 15'd20000;
    tick(16'sd10);
    repeat (8) tick(16'sd0);
    open_level_i = 15'd3;
    tick(16'sd0);
    checks++;
    if (gate_open_o !== 1'b0) begin
      $display("FAIL peak2 gate=%b exp 0", gate_open_o);
      errors++;
    end
    open_level_i = 15'd1;
    tick(16'sd0);
    checks++;
    if (gate_open_o !== 1'b1 || data_o !== 16'sd0) begin
      $display("FAIL peak1 gate=%b data_o=%0d exp 1/0",
               gate_open_o, data_o);
      errors++;
    end
    do_reset();
    open_level_i = 15'd20000;
    tick(16'sd10);
    repeat (10) tick(16'sd0);
    open_level_i = 15'd1;
    for (int i = 0; i < 2; i++) begin
      tick(16'sd0);
      checks++;
      if (gate_open_o !== 1'b0) begin
        $display("FAIL peak0 p%0d gate=%b exp 0",
                 i, gate_open_o);
        errors++;
      end
    end
  endtask

  initial begin
    srst_i = 1'b1;
    sample_tick_i = 1'b0;
    enable_i = 1'b1;
    open_level_i = 15'd2000;
    close_level_i = 15'd1000;
    hold_samples_i = 16'd5;
    data_i = 16'sd0;
    test_reset();
    test_open_ramp();
    test_hold_release();
    test_retrigger();
    test_release_zero();
    test_bypass();
    test_peak_decay();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
